// File: rtl/simd_cfg_pkg.sv
// -----------------------------------------------------------------------------
// simd_cfg_pkg
// Shared definitions for the SIMD boot/dump sequencer:
//   - cfg_state_e : sequencer FSM states
//   - DEF_CFG_*   : default widths/depths for the controller parameters
//   - next_ch()   : walks the channel-enable mask in ascending order
// No ports (package).
// -----------------------------------------------------------------------------
package simd_cfg_pkg;

  localparam int DEF_CFG_NUM_CH    = 3;
  localparam int DEF_CFG_ADDR_W    = 10;
  localparam int DEF_CFG_DEPTH     = 1024;
  localparam int DEF_CFG_DATA_W    = 64;
  localparam int DEF_CFG_PC_W      = 10;
  localparam int DEF_CFG_FIN_CNT   = 4;
  localparam int DEF_CFG_TIMEOUT_W = 24;

  // Widest mask next_ch() can scan; NUM_CH must not exceed this.
  localparam int CFG_MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_HOLD,
    ST_DONE
  } cfg_state_e;

  // Lowest set mask bit strictly above 'ch'. Pass ch = -1 to get the first
  // enabled channel. Returns CFG_MAX_CH when no further channel is enabled.
  function automatic int next_ch(input logic [CFG_MAX_CH-1:0] mask, input int ch);
    int res;
    res = CFG_MAX_CH;
    for (int i = CFG_MAX_CH - 1; i >= 0; i--) begin
      if ((i > ch) && mask[i]) res = i;
    end
    return res;
  endfunction

endpackage

// File: rtl/simd_finish_detect.sv
// -----------------------------------------------------------------------------
// simd_finish_detect
// Program-end detection while the core runs.
//   - A PC that stays unchanged for FIN_CNT consecutive cycles is a self-jump,
//     reported as a one-cycle oFinish pulse.
//   - A watchdog counts enabled cycles and pulses oTimeout when the count
//     reaches iTimeout (iTimeout == 0 disables it).
// Ports:
//   rClk      in   clock, posedge
//   rReset    in   synchronous, active-low reset
//   iEnable   in   high while the core is running; low clears all tracking
//   iPC       in   PC_W   core PC
//   iTimeout  in   TIMEOUT_W watchdog limit in cycles
//   oFinish   out  finish pulse (combinational)
//   oTimeout  out  watchdog pulse (combinational)
// -----------------------------------------------------------------------------
module simd_finish_detect #(
  parameter int PC_W      = 10,
  parameter int FIN_CNT   = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 rClk,
  input  logic                 rReset,
  input  logic                 iEnable,
  input  logic [PC_W-1:0]      iPC,
  input  logic [TIMEOUT_W-1:0] iTimeout,
  output logic                 oFinish,
  output logic                 oTimeout
);

  localparam int CNT_W = $clog2(FIN_CNT + 1);
  localparam logic [CNT_W-1:0] FIN_LIM = CNT_W'(FIN_CNT - 1);

  logic [PC_W-1:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0]     stable_cnt_q, stable_cnt_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 pc_same;

  // The stable counter holds the number of back-to-back repeats of the PC,
  // so FIN_CNT cycles at one PC means FIN_CNT-1 repeats. Tracking restarts
  // from zero every time the core is let out of reset.
  always_comb begin
    pc_same      = (iPC == last_pc_q);
    last_pc_d    = '0;
    stable_cnt_d = '0;
    wd_cnt_d     = '0;
    if (iEnable) begin
      last_pc_d = iPC;
      if (pc_same) begin
        stable_cnt_d = (stable_cnt_q == FIN_LIM) ? stable_cnt_q : stable_cnt_q + 1'b1;
      end
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    oFinish  = iEnable && (stable_cnt_d == FIN_LIM);
    oTimeout = iEnable && (iTimeout != '0) && (wd_cnt_d == iTimeout);
  end

  always_ff @(posedge rClk) begin
    if (!rReset) begin
      last_pc_q    <= '0;
      stable_cnt_q <= '0;
      wd_cnt_q     <= '0;
    end else begin
      last_pc_q    <= last_pc_d;
      stable_cnt_q <= stable_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/simd_mem_config_ctrl.sv
// -----------------------------------------------------------------------------
// simd_mem_config_ctrl
// Boot/dump sequencer for the SIMD top (CP + PE array). Loads every enabled
// memory channel from a valid/ready stream, releases the core, waits for a
// PC self-jump (or watchdog), freezes the core and streams every enabled
// channel back out.
// Ports:
//   rClk, rReset            clock (posedge), synchronous active-low reset
//   iStart, iCh_Mask        start pulse and channel-enable mask (IDLE/DONE)
//   iTimeout                RUN watchdog limit, 0 = disabled
//   iLd_Valid/iLd_Data/oLd_Ready   load stream
//   oBus_Valid (one-hot), oBus_Address, oBus_Write_Data, oBus_Write_Enable
//   iBus_Read_Data          per-channel read data, 1-cycle latency
//   oCore_Reset             core reset, active high
//   iPC                     core PC
//   oDp_Valid/oDp_Data/oDp_Last/iDp_Ready   dump stream
//   oFinished, oTimeout, oDone              sticky status flags
// -----------------------------------------------------------------------------
module simd_mem_config_ctrl
  import simd_cfg_pkg::*;
#(
  parameter int NUM_CH    = DEF_CFG_NUM_CH,
  parameter int ADDR_W    = DEF_CFG_ADDR_W,
  parameter int DEPTH     = DEF_CFG_DEPTH,
  parameter int DATA_W    = DEF_CFG_DATA_W,
  parameter int PC_W      = DEF_CFG_PC_W,
  parameter int FIN_CNT   = DEF_CFG_FIN_CNT,
  parameter int TIMEOUT_W = DEF_CFG_TIMEOUT_W
) (
  input  logic                     rClk,
  input  logic                     rReset,
  input  logic                     iStart,
  input  logic [NUM_CH-1:0]        iCh_Mask,
  input  logic [TIMEOUT_W-1:0]     iTimeout,
  input  logic                     iLd_Valid,
  input  logic [DATA_W-1:0]        iLd_Data,
  output logic                     oLd_Ready,
  output logic [NUM_CH-1:0]        oBus_Valid,
  output logic [ADDR_W-1:0]        oBus_Address,
  output logic [DATA_W-1:0]        oBus_Write_Data,
  output logic                     oBus_Write_Enable,
  input  logic [NUM_CH*DATA_W-1:0] iBus_Read_Data,
  output logic                     oCore_Reset,
  input  logic [PC_W-1:0]          iPC,
  output logic                     oDp_Valid,
  output logic [DATA_W-1:0]        oDp_Data,
  output logic                     oDp_Last,
  input  logic                     iDp_Ready,
  output logic                     oFinished,
  output logic                     oTimeout,
  output logic                     oDone
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  cfg_state_e          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                finished_q, finished_d;
  logic                timeout_q, timeout_d;
  logic                done_q, done_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   dp_data_q, dp_data_d;

  logic                fin_pulse, to_pulse;
  int                  first_start, first_run, nxt;
  logic                wrap, last_word;
  logic [ADDR_W-1:0]   adv_addr;
  logic [CH_W-1:0]     adv_ch;
  logic [NUM_CH-1:0]   cur_onehot, adv_onehot;
  logic [DATA_W-1:0]   rd_slice, dp_out;

  simd_finish_detect #(
    .PC_W      (PC_W),
    .FIN_CNT   (FIN_CNT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_finish_detect (
    .rClk     (rClk),
    .rReset   (rReset),
    .iEnable  (state_q == ST_RUN),
    .iPC      (iPC),
    .iTimeout (iTimeout),
    .oFinish  (fin_pulse),
    .oTimeout (to_pulse)
  );

  // Address/channel stepping shared by LOAD and DUMP. The address wraps at
  // DEPTH-1 (not at 2**ADDR_W); after the last enabled channel the channel
  // pointer rewinds to the first one so the next phase starts in place.
  always_comb begin
    first_start = next_ch(CFG_MAX_CH'(iCh_Mask), -1);
    first_run   = next_ch(CFG_MAX_CH'(mask_q), -1);
    nxt         = next_ch(CFG_MAX_CH'(mask_q), int'(ch_q));
    wrap        = (addr_q == LAST_ADDR);
    last_word   = wrap && (nxt >= NUM_CH);
    adv_addr    = wrap ? '0 : addr_q + 1'b1;
    adv_ch      = ch_q;
    if (wrap) adv_ch = (nxt < NUM_CH) ? CH_W'(nxt) : CH_W'(first_run);
    cur_onehot  = NUM_CH'(1) << ch_q;
    adv_onehot  = NUM_CH'(1) << adv_ch;
  end

  // Read data arrives the cycle after the strobe, i.e. in the first HOLD
  // cycle. It is forwarded straight to the dump port then and held in
  // dp_data_q for any stall cycles that follow.
  always_comb begin
    rd_slice = iBus_Read_Data[int'(ch_q)*DATA_W +: DATA_W];
    dp_out   = first_q ? rd_slice : dp_data_q;
  end

  // Sequencer. All bus strobes are computed here and registered, so a strobe
  // always appears the cycle after the decision; read strobes are issued on
  // the transition into DUMP_RD so the data lands in the first HOLD cycle.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    bus_valid_d  = '0;
    bus_we_d     = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    core_reset_d = core_reset_q;
    finished_d   = finished_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    first_d      = (state_q == ST_DUMP_RD);
    dp_data_d    = dp_out;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart && (iCh_Mask != '0)) begin
          state_d    = ST_LOAD;
          mask_d     = iCh_Mask;
          ch_d       = CH_W'(first_start);
          addr_d     = '0;
          finished_d = 1'b0;
          timeout_d  = 1'b0;
          done_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (iLd_Valid) begin
          bus_valid_d = cur_onehot;
          bus_we_d    = 1'b1;
          bus_addr_d  = addr_q;
          bus_wdata_d = iLd_Data;
          addr_d      = adv_addr;
          ch_d        = adv_ch;
          if (last_word) begin
            state_d      = ST_RUN;
            core_reset_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (fin_pulse || to_pulse) begin
          finished_d   = finished_q | fin_pulse;
          timeout_d    = timeout_q | to_pulse;
          core_reset_d = 1'b1;
          state_d      = ST_DUMP_RD;
          bus_valid_d  = cur_onehot;
          bus_addr_d   = addr_q;
        end
      end
      ST_DUMP_RD: begin
        state_d = ST_DUMP_HOLD;
      end
      ST_DUMP_HOLD: begin
        if (iDp_Ready) begin
          addr_d = adv_addr;
          ch_d   = adv_ch;
          if (last_word) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_DUMP_RD;
            bus_valid_d = adv_onehot;
            bus_addr_d  = adv_addr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rClk) begin
    if (!rReset) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      bus_valid_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      first_q      <= 1'b0;
      dp_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      core_reset_q <= core_reset_d;
      finished_q   <= finished_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      first_q      <= first_d;
      dp_data_q    <= dp_data_d;
    end
  end

  assign oLd_Ready         = (state_q == ST_LOAD);
  assign oBus_Valid        = bus_valid_q;
  assign oBus_Address      = bus_addr_q;
  assign oBus_Write_Data   = bus_wdata_q;
  assign oBus_Write_Enable = bus_we_q;
  assign oCore_Reset       = core_reset_q;
  assign oDp_Valid         = (state_q == ST_DUMP_HOLD);
  assign oDp_Data          = dp_out;
  assign oDp_Last          = (state_q == ST_DUMP_HOLD) && wrap;
  assign oFinished         = finished_q;
  assign oTimeout          = timeout_q;
  assign oDone             = done_q;

endmodule

// File: tb/tb_simd_mem_config_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simd_mem_config_ctrl
// Directed bench for the boot/dump sequencer with a small 3-channel memory
// model (8 words per channel, 4-bit addresses so the DEPTH wrap is visible).
// -----------------------------------------------------------------------------
module tb_simd_mem_config_ctrl;

  localparam int NUM_CH    = 3;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 8;
  localparam int DATA_W    = 16;
  localparam int PC_W      = 10;
  localparam int FIN_CNT   = 4;
  localparam int TIMEOUT_W = 24;

  logic                     rClk;
  logic                     rReset;
  logic                     iStart;
  logic [NUM_CH-1:0]        iCh_Mask;
  logic [TIMEOUT_W-1:0]     iTimeout;
  logic                     iLd_Valid;
  logic [DATA_W-1:0]        iLd_Data;
  logic                     oLd_Ready;
  logic [NUM_CH-1:0]        oBus_Valid;
  logic [ADDR_W-1:0]        oBus_Address;
  logic [DATA_W-1:0]        oBus_Write_Data;
  logic                     oBus_Write_Enable;
  logic [NUM_CH*DATA_W-1:0] iBus_Read_Data;
  logic                     oCore_Reset;
  logic [PC_W-1:0]          iPC;
  logic                     oDp_Valid;
  logic [DATA_W-1:0]        oDp_Data;
  logic                     oDp_Last;
  logic                     iDp_Ready;
  logic                     oFinished;
  logic                     oTimeout;
  logic                     oDone;

  int total = 0;
  int bad   = 0;

  simd_mem_config_ctrl #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .FIN_CNT   (FIN_CNT),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .rClk              (rClk),
    .rReset            (rReset),
    .iStart            (iStart),
    .iCh_Mask          (iCh_Mask),
    .iTimeout          (iTimeout),
    .iLd_Valid         (iLd_Valid),
    .iLd_Data          (iLd_Data),
    .oLd_Ready         (oLd_Ready),
    .oBus_Valid        (oBus_Valid),
    .oBus_Address      (oBus_Address),
    .oBus_Write_Data   (oBus_Write_Data),
    .oBus_Write_Enable (oBus_Write_Enable),
    .iBus_Read_Data    (iBus_Read_Data),
    .oCore_Reset       (oCore_Reset),
    .iPC               (iPC),
    .oDp_Valid         (oDp_Valid),
    .oDp_Data          (oDp_Data),
    .oDp_Last          (oDp_Last),
    .iDp_Ready         (iDp_Ready),
    .oFinished         (oFinished),
    .oTimeout          (oTimeout),
    .oDone             (oDone)
  );

  initial rClk = 1'b0;
  always #5 rClk = ~rClk;

  // Memory model: writes land at the strobe edge, reads return one cycle
  // later on the channel's read-data slice. Also logs writes and counts
  // reads, ch1 strobes and multi-hot strobes.
  logic [DATA_W-1:0] mem  [NUM_CH][16];
  logic [DATA_W-1:0] rd_q [NUM_CH];
  logic [31:0]       wlog [$];
  int                n_reads = 0;
  int                n_ch1   = 0;
  int                n_multi = 0;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      rd_q[c] = '0;
      for (int a = 0; a < 16; a++) mem[c][a] = '0;
    end
  end

  always @(posedge rClk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (oBus_Valid[c]) begin
        if (oBus_Write_Enable) begin
          mem[c][oBus_Address] <= oBus_Write_Data;
          wlog.push_back({8'(c), 8'(oBus_Address), oBus_Write_Data});
        end else begin
          rd_q[c] <= mem[c][oBus_Address];
          n_reads++;
        end
      end
    end
    if ($countones(oBus_Valid) > 1) n_multi++;
    if (oBus_Valid[1]) n_ch1++;
  end

  assign iBus_Read_Data = {rd_q[2], rd_q[1], rd_q[0]};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rClk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int pcs [7] = '{1, 2, 3, 5, 5, 5, 5};
  int hs_cycle [16];
  int received;
  int cycles;
  int reads_snap;
  bit stalled;
  logic [DATA_W-1:0] snap;

  initial begin
    rReset    = 1'b0;
    iStart    = 1'b0;
    iCh_Mask  = '0;
    iTimeout  = '0;
    iLd_Valid = 1'b0;
    iLd_Data  = '0;
    iPC       = '0;
    iDp_Ready = 1'b0;

    // Reset state
    tick(5);
    check_output("rst_core_reset", 64'(oCore_Reset), 64'd1);
    check_output("rst_bus_valid", 64'(oBus_Valid), 64'd0);
    check_output("rst_ld_ready", 64'(oLd_Ready), 64'd0);
    check_output("rst_flags", 64'({oFinished, oTimeout, oDone, oDp_Valid}), 64'd0);
    rReset = 1'b1;
    tick(1);

    // A start with an empty mask is ignored
    iStart = 1'b1; iCh_Mask = 3'b000;
    tick(1);
    iStart = 1'b0;
    tick(1);
    check_output("zero_mask_ignored", 64'(oLd_Ready), 64'd0);

    // Load ch0 and ch2, ch0 with a bubble after every beat
    iStart = 1'b1; iCh_Mask = 3'b101;
    tick(1);
    iStart = 1'b0; iCh_Mask = '0;
    check_output("load_ready", 64'(oLd_Ready), 64'd1);
    check_output("load_core_reset", 64'(oCore_Reset), 64'd1);
    for (int w = 0; w < 16; w++) begin
      iLd_Valid = 1'b1;
      iLd_Data  = DATA_W'(w);
      tick(1);
      if (w == 0)
        check_output("first_write_strobe",
                     64'({oBus_Valid, oBus_Write_Enable, oBus_Address, oBus_Write_Data}),
                     64'({3'b001, 1'b1, 4'd0, 16'd0}));
      if (w == 14) check_output("core_reset_during_load", 64'(oCore_Reset), 64'd1);
      if (w < 8) begin
        iLd_Valid = 1'b0;
        tick(1);
        if (w == 2) check_output("bubble_no_strobe", 64'(oBus_Valid), 64'd0);
      end
    end
    iLd_Valid = 1'b0;
    check_output("core_reset_released", 64'(oCore_Reset), 64'd0);
    check_output("ld_ready_off", 64'(oLd_Ready), 64'd0);
    check_output("last_write_strobe",
                 64'({oBus_Valid, oBus_Write_Enable, oBus_Address, oBus_Write_Data}),
                 64'({3'b100, 1'b1, 4'd7, 16'd15}));

    // Finish on the 4th consecutive cycle of PC=5
    for (int i = 0; i < 7; i++) begin
      iPC = PC_W'(pcs[i]);
      tick(1);
      if (i == 5) check_output("not_finished_early", 64'(oFinished), 64'd0);
    end
    check_output("finished_set", 64'(oFinished), 64'd1);
    check_output("finish_no_timeout", 64'(oTimeout), 64'd0);
    check_output("core_frozen", 64'(oCore_Reset), 64'd1);
    check_output("first_read_strobe",
                 64'({oBus_Valid, oBus_Write_Enable, oBus_Address}),
                 64'({3'b001, 1'b0, 4'd0}));

    check_output("write_count", 64'(wlog.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check_output("write_log", 64'((i < wlog.size()) ? wlog[i] : 32'hFFFF_FFFF),
                   64'({8'((i < 8) ? 0 : 2), 8'(i % 8), 16'(i)}));
    end

    // Dump with a 10-cycle stall on word 3
    iDp_Ready = 1'b1;
    received  = 0;
    cycles    = 0;
    stalled   = 1'b0;
    while (received < 16 && cycles < 400) begin
      if (received == 3 && !stalled && oDp_Valid) begin
        iDp_Ready  = 1'b0;
        snap       = oDp_Data;
        reads_snap = n_reads;
        tick(10);
        cycles += 10;
        check_output("stall_data_value", 64'(snap), 64'd3);
        check_output("stall_data_stable", 64'(oDp_Data), 64'(snap));
        check_output("stall_valid_held", 64'(oDp_Valid), 64'd1);
        check_output("stall_no_reads", 64'(n_reads), 64'(reads_snap));
        stalled   = 1'b1;
        iDp_Ready = 1'b1;
      end
      if (oDp_Valid && iDp_Ready) begin
        check_output("dump_data", 64'(oDp_Data), 64'(received));
        check_output("dump_last", 64'(oDp_Last), 64'((received % 8) == 7));
        hs_cycle[received] = cycles;
        received++;
      end
      tick(1);
      cycles++;
    end
    check_output("dump_count", 64'(received), 64'd16);
    check_output("dump_done", 64'(oDone), 64'd1);
    check_output("dump_valid_off", 64'(oDp_Valid), 64'd0);
    check_output("read_count", 64'(n_reads), 64'd16);
    check_output("dump_rate", 64'(hs_cycle[6] - hs_cycle[5]), 64'd2);
    check_output("ch1_never_strobed", 64'(n_ch1), 64'd0);

    // Restart from DONE with ch1 only, then let the watchdog fire
    iTimeout = 24'd20;
    iStart = 1'b1; iCh_Mask = 3'b010;
    tick(1);
    iStart = 1'b0; iCh_Mask = '0;
    check_output("restart_clears_flags", 64'({oDone, oFinished, oTimeout}), 64'd0);
    check_output("restart_loading", 64'(oLd_Ready), 64'd1);
    for (int w = 0; w < 8; w++) begin
      iLd_Valid = 1'b1;
      iLd_Data  = DATA_W'(100 + w);
      tick(1);
    end
    iLd_Valid = 1'b0;
    check_output("restart_core_released", 64'(oCore_Reset), 64'd0);
    for (int i = 0; i < 19; i++) begin
      iPC = PC_W'(i * 3 + 7);
      tick(1);
    end
    check_output("timeout_not_early", 64'(oTimeout), 64'd0);
    iPC = PC_W'(500);
    tick(1);
    check_output("timeout_set", 64'(oTimeout), 64'd1);
    check_output("timeout_no_finish", 64'(oFinished), 64'd0);
    check_output("timeout_core_frozen", 64'(oCore_Reset), 64'd1);

    // Dump two words, then abort with reset mid-dump
    iDp_Ready = 1'b1;
    tick(1);
    check_output("wd_dump_word0", 64'({oDp_Valid, oDp_Data}), 64'({1'b1, 16'd100}));
    tick(2);
    check_output("wd_dump_word1", 64'({oDp_Valid, oDp_Data}), 64'({1'b1, 16'd101}));
    rReset = 1'b0;
    tick(1);
    check_output("abort_core_reset", 64'(oCore_Reset), 64'd1);
    check_output("abort_outputs", 64'({oBus_Valid, oDp_Valid, oTimeout, oLd_Ready}), 64'd0);
    tick(1);
    check_output("abort_no_strobe", 64'(oBus_Valid), 64'd0);
    rReset = 1'b1;
    tick(2);
    check_output("abort_idle", 64'({oLd_Ready, oDp_Valid, oBus_Valid, oCore_Reset}), 64'd1);

    // A new load after the abort starts over at address 0
    iStart = 1'b1; iCh_Mask = 3'b010;
    tick(1);
    iStart = 1'b0; iCh_Mask = '0;
    iLd_Valid = 1'b1;
    iLd_Data  = 16'd77;
    tick(1);
    iLd_Valid = 1'b0;
    check_output("reload_from_zero",
                 64'({oBus_Valid, oBus_Write_Enable, oBus_Address, oBus_Write_Data}),
                 64'({3'b010, 1'b1, 4'd0, 16'd77}));
    check_output("one_hot_bus", 64'(n_multi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
